// File: rtl/ldtu_pkg.sv
// Shared LiTe-DTU definitions: encoder FSM state codes, packer word headers,
// the idle fill pattern and accumulator slot counts.
package ldtu_pkg;

    localparam logic [3:0] ST_IDLE   = 4'b0000;
    localparam logic [3:0] ST_BAS_0  = 4'b0001;
    localparam logic [3:0] ST_BAS_1  = 4'b0010;
    localparam logic [3:0] ST_BAS_2  = 4'b0011;
    localparam logic [3:0] ST_BAS_3  = 4'b0100;
    localparam logic [3:0] ST_BAS_4  = 4'b0101;
    localparam logic [3:0] ST_SIGN_0 = 4'b0110;
    localparam logic [3:0] ST_SIGN_1 = 4'b0111;
    localparam logic [3:0] ST_NONE   = 4'b1111;

    localparam int BASE_SLOTS = 5;
    localparam int SIG_SLOTS  = 2;
    localparam int BASE_BITS  = 6;
    localparam int SIG_BITS   = 13;

    localparam logic [1:0]  HDR_BASE_FULL  = 2'b01;
    localparam logic [3:0]  HDR_BASE_PART  = 4'b1100;
    localparam logic [5:0]  HDR_SIG_PAIR   = 6'b001010;
    localparam logic [5:0]  HDR_SIG_SINGLE = 6'b001011;
    localparam logic [31:0] IDLE_WORD      = 32'hEAAA_AAAA;

    typedef enum logic [1:0] {
        W_BASE_FULL,
        W_BASE_PART,
        W_SIG_PAIR,
        W_SIG_SINGLE
    } word_kind_e;

    typedef logic [BASE_SLOTS-1:0][BASE_BITS-1:0] base_slots_t;
    typedef logic [SIG_SLOTS-1:0][SIG_BITS-1:0]   sig_slots_t;

    function automatic logic is_base_state(input logic [3:0] s);
        return (s >= ST_BAS_0) && (s <= ST_BAS_4);
    endfunction

endpackage

// File: rtl/ldtu_word_packer_if.sv
// Packer data-path bundle: encoder state/sample in, packed word stream out.
interface ldtu_word_packer_if #(
    parameter int SIZE   = 3,
    parameter int SIG_W  = 13,
    parameter int WORD_W = 32
);
    logic [SIZE:0]       state_in;
    logic [SIG_W-1:0]    sample_in;
    logic [WORD_W-1:0]   word_out;
    logic                word_valid;
    logic                seq_err;

    modport master (
        output state_in, sample_in,
        input  word_out, word_valid, seq_err
    );

    modport slave (
        input  state_in, sample_in,
        output word_out, word_valid, seq_err
    );
endinterface

// File: rtl/ldtu_word_format.sv
// Combinational assembly of one 32-bit output word from accumulator slots.
module ldtu_word_format
    import ldtu_pkg::*;
(
    input  word_kind_e  kind,
    input  logic [2:0]  cnt,
    input  base_slots_t base,
    input  sig_slots_t  sig,
    output logic [31:0] word
);

    logic [3:0][BASE_BITS-1:0] part;

    always_comb begin
        part = '0;
        for (int i = 0; i < 4; i++) begin
            // Slots beyond the fill count may hold stale data; force them to zero.
            if (3'(i) < cnt) part[i] = base[i];
        end
        word = '0;
        unique case (kind)
            W_BASE_FULL:  word = {HDR_BASE_FULL, base[0], base[1], base[2], base[3], base[4]};
            W_BASE_PART:  word = {HDR_BASE_PART, cnt, 1'b0, part[0], part[1], part[2], part[3]};
            W_SIG_PAIR:   word = {HDR_SIG_PAIR, sig[0], sig[1]};
            W_SIG_SINGLE: word = {HDR_SIG_SINGLE, sig[0], 13'd0};
            default:      word = '0;
        endcase
    end

endmodule

// File: rtl/ldtu_word_packer.sv
// LiTe-DTU word packer: baseline/signal samples into 32-bit serializer words.
// Optional LDTU_PACKER_IDLE_WORD_EN drives the idle fill pattern on empty cycles.
module ldtu_word_packer
    import ldtu_pkg::*;
#(
    parameter int SIZE   = 3,
    parameter int BASE_W = 6,
    parameter int SIG_W  = 13,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    ldtu_word_packer_if.slave bus
);

    if (SIZE != 3 || BASE_W != BASE_BITS || SIG_W != SIG_BITS || WORD_W != 32) begin : g_bad_cfg
        $error("ldtu_word_packer: only default widths supported");
    end

`ifdef LDTU_PACKER_IDLE_WORD_EN
    localparam logic [31:0] FILL_WORD = IDLE_WORD;
`else
    localparam logic [31:0] FILL_WORD = 32'd0;
`endif

    logic [3:0]  st;
    logic [2:0]  k;
    base_slots_t b_slot, b_nxt;
    sig_slots_t  s_slot, s_nxt;
    logic [2:0]  b_cnt, b_cnt_nxt;
    logic        s_cnt, s_cnt_nxt;
    logic        clr_b, clr_s, emit, err_set;
    word_kind_e  kind;
    logic [31:0] fmt_word;

    assign st = 4'(bus.state_in);
    assign k  = st[2:0] - 3'd1;

    always_comb begin
        b_nxt     = b_slot;
        s_nxt     = s_slot;
        b_cnt_nxt = b_cnt;
        s_cnt_nxt = s_cnt;
        clr_b     = 1'b0;
        clr_s     = 1'b0;
        emit      = 1'b0;
        kind      = W_BASE_FULL;
        err_set   = 1'b0;
        if (is_base_state(st)) begin
            if (b_cnt != k) err_set = 1'b1;
            if (s_cnt) begin
                emit      = 1'b1;
                kind      = W_SIG_SINGLE;
                s_cnt_nxt = 1'b0;
                clr_s     = 1'b1;
            end
            // Write goes to slot k even after a sequence error, re-syncing the count.
            b_nxt[k] = bus.sample_in[BASE_W-1:0];
            if (k == 3'd4) begin
                // Only reachable together with a signal flush after a sequence
                // error; the completed baseline word wins.
                emit      = 1'b1;
                kind      = W_BASE_FULL;
                b_cnt_nxt = 3'd0;
                clr_b     = 1'b1;
            end else begin
                b_cnt_nxt = k + 3'd1;
            end
        end else if (st == ST_IDLE || st == ST_NONE) begin
            if (b_cnt != 3'd0) begin
                emit      = 1'b1;
                kind      = W_BASE_PART;
                b_cnt_nxt = 3'd0;
                clr_b     = 1'b1;
            end else if (s_cnt) begin
                emit      = 1'b1;
                kind      = W_SIG_SINGLE;
                s_cnt_nxt = 1'b0;
                clr_s     = 1'b1;
            end
        end else begin
            if (b_cnt != 3'd0) begin
                emit      = 1'b1;
                kind      = W_BASE_PART;
                b_cnt_nxt = 3'd0;
                clr_b     = 1'b1;
            end
            s_nxt[s_cnt] = bus.sample_in;
            if (s_cnt) begin
                emit      = 1'b1;
                kind      = W_SIG_PAIR;
                s_cnt_nxt = 1'b0;
                clr_s     = 1'b1;
            end else begin
                s_cnt_nxt = 1'b1;
            end
        end
    end

    ldtu_word_format u_fmt (
        .kind (kind),
        .cnt  (b_cnt),
        .base (b_nxt),
        .sig  (s_nxt),
        .word (fmt_word)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            b_slot         <= '0;
            s_slot         <= '0;
            b_cnt          <= 3'd0;
            s_cnt          <= 1'b0;
            bus.word_out   <= FILL_WORD;
            bus.word_valid <= 1'b0;
            bus.seq_err    <= 1'b0;
        end else begin
            b_slot         <= clr_b ? '0 : b_nxt;
            s_slot         <= clr_s ? '0 : s_nxt;
            b_cnt          <= b_cnt_nxt;
            s_cnt          <= s_cnt_nxt;
            bus.word_valid <= emit;
            bus.seq_err    <= bus.seq_err | err_set;
`ifdef LDTU_PACKER_IDLE_WORD_EN
            bus.word_out   <= emit ? fmt_word : FILL_WORD;
`else
            if (emit) bus.word_out <= fmt_word;
`endif
        end
    end

endmodule

// File: tb/tb_ldtu_word_packer.sv
// Directed vector bench for ldtu_word_packer (table rows plus reset/sequence corner cases).
module tb_ldtu_word_packer;
    import ldtu_pkg::*;

    typedef struct {
        logic        rst;
        logic [3:0]  st;
        logic [12:0] smp;
        logic        vld;
        logic [31:0] word;
        logic        err;
    } vec_t;

`ifdef LDTU_PACKER_IDLE_WORD_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] last_word;
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    ldtu_word_packer_if #(.SIZE(3), .SIG_W(13), .WORD_W(32)) bus ();

    ldtu_word_packer #(.SIZE(3), .BASE_W(6), .SIG_W(13), .WORD_W(32)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic rst, input logic [3:0] st, input logic [12:0] smp,
                                input logic vld, input logic [31:0] word, input logic err);
        vec_t v;
        v.rst = rst; v.st = st; v.smp = smp; v.vld = vld; v.word = word; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        logic [31:0] ew;
        @(negedge CLK);
        reset         = v.rst;
        bus.state_in  = v.st;
        bus.sample_in = v.smp;
        @(posedge CLK);
        #1;
        if (v.rst)      ew = IDLE_EN ? IDLE_WORD : 32'd0;
        else if (v.vld) ew = v.word;
        else            ew = IDLE_EN ? IDLE_WORD : last_word;
        last_word = ew;
        chk({nm, ".valid"}, 32'(bus.word_valid), 32'(v.vld));
        chk({nm, ".word"},  bus.word_out, ew);
        chk({nm, ".seq_err"}, 32'(bus.seq_err), 32'(v.err));
    endtask

    initial begin
        reset = 1'b1;
        bus.state_in  = '0;
        bus.sample_in = '0;
        last_word = '0;

        tbl.push_back(mk(1, ST_IDLE, 13'h0, 0, 0, 0));
        // full baseline 1..5
        tbl.push_back(mk(0, ST_BAS_0, 13'd1, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_1, 13'd2, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_2, 13'd3, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_3, 13'd4, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_4, 13'd5, 1, 32'h4108_3105, 0));
        tbl.push_back(mk(0, ST_IDLE,  13'd0, 0, 0, 0));
        // signal pair
        tbl.push_back(mk(0, ST_SIGN_0, 13'h1ABC, 0, 0, 0));
        tbl.push_back(mk(0, ST_SIGN_1, 13'h0123, 1, 32'h2B57_8123, 0));
        // partial baseline flushed by a signal sample
        tbl.push_back(mk(0, ST_BAS_0,  13'd7,    0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_1,  13'd9,    0, 0, 0));
        tbl.push_back(mk(0, ST_SIGN_0, 13'h0FFF, 1, 32'hC41C_9000, 0));
        tbl.push_back(mk(0, ST_SIGN_1, 13'h0001, 1, 32'h29FF_E001, 0));
        // single signal flushed by idle, then idle/1111 stay quiet
        tbl.push_back(mk(0, ST_SIGN_0, 13'h0010, 0, 0, 0));
        tbl.push_back(mk(0, ST_IDLE,   13'd0,    1, 32'h2C02_0000, 0));
        tbl.push_back(mk(0, ST_IDLE,   13'd0,    0, 0, 0));
        tbl.push_back(mk(0, ST_NONE,   13'h1FFF, 0, 0, 0));
        // single signal flushed by a baseline sample; upper sample bits ignored
        tbl.push_back(mk(0, ST_SIGN_0, 13'h0AAA, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_0,  13'h1FFF, 1, 32'h2D55_4000, 0));
        tbl.push_back(mk(0, ST_IDLE,   13'd0,    1, 32'hC2FC_0000, 0));
        // bis states count as signal
        tbl.push_back(mk(0, 4'b1010, 13'h0005, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1110, 13'h0006, 1, 32'h2800_A006, 0));
        // partial with count 4, flushed by state 1111
        tbl.push_back(mk(0, ST_BAS_0, 13'd1, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_1, 13'd2, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_2, 13'd3, 0, 0, 0));
        tbl.push_back(mk(0, ST_BAS_3, 13'd4, 0, 0, 0));
        tbl.push_back(mk(0, ST_NONE,  13'd0, 1, 32'hC804_20C4, 0));
        tbl.push_back(mk(0, ST_IDLE,  13'd0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // sequence error: bas_1 skipped, slot 1 stays zero, flag sticky
        apply(mk(1, ST_IDLE,  13'd0, 0, 0, 0), "seq.rst");
        apply(mk(0, ST_BAS_0, 13'd5, 0, 0, 0), "seq.b0");
        apply(mk(0, ST_BAS_2, 13'd6, 0, 0, 1), "seq.b2");
        apply(mk(0, ST_BAS_3, 13'd8, 0, 0, 1), "seq.b3");
        apply(mk(0, ST_BAS_4, 13'd9, 1, 32'h4500_6209, 1), "seq.b4");
        apply(mk(0, ST_IDLE,  13'd0, 0, 0, 1), "seq.idle");

        // mid-operation reset discards partial data, no flush afterwards
        apply(mk(1, ST_IDLE,  13'd0, 0, 0, 0), "mid.rst0");
        apply(mk(0, ST_BAS_0, 13'd1, 0, 0, 0), "mid.b0");
        apply(mk(0, ST_BAS_1, 13'd2, 0, 0, 0), "mid.b1");
        apply(mk(0, ST_BAS_2, 13'd3, 0, 0, 0), "mid.b2");
        apply(mk(1, ST_BAS_3, 13'd4, 0, 0, 0), "mid.rst1");
        apply(mk(0, ST_IDLE,  13'd0, 0, 0, 0), "mid.idle0");
        apply(mk(0, ST_IDLE,  13'd0, 0, 0, 0), "mid.idle1");
        apply(mk(0, ST_BAS_0, 13'd1, 0, 0, 0), "mid.f0");
        apply(mk(0, ST_BAS_1, 13'd2, 0, 0, 0), "mid.f1");
        apply(mk(0, ST_BAS_2, 13'd3, 0, 0, 0), "mid.f2");
        apply(mk(0, ST_BAS_3, 13'd4, 0, 0, 0), "mid.f3");
        apply(mk(0, ST_BAS_4, 13'd5, 1, 32'h4108_3105, 0), "mid.f4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
